// File: rtl/core_bank_adapter.sv
// core_bank_adapter: RI5CY 32-bit data port to 64-bit bank request port.
// Lane steering, AMO decode, AMO write-back blocking, local atomic errors.
module core_bank_adapter #(
    parameter int unsigned AddrMemWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic                    data_err_o,
    input  logic [31:0]             data_addr_i,
    input  logic                    data_we_i,
    input  logic [3:0]              data_be_i,
    input  logic [31:0]             data_wdata_i,
    input  logic [5:0]              data_atop_i,
    input  logic                    data_lim_i,
    input  logic [2:0]              data_lim_op_i,
    input  logic [31:0]             data_lim_asize_i,
    output logic [31:0]             data_rdata_o,
    output logic                    bank_req_o,
    input  logic                    bank_gnt_i,
    output logic [AddrMemWidth-1:0] bank_add_o,
    output logic [3:0]              bank_amo_o,
    output logic                    bank_wen_o,
    output logic [63:0]             bank_wdata_o,
    output logic [7:0]              bank_be_o,
    output logic                    bank_lim_o,
    output logic [2:0]              bank_lim_op_o,
    output logic [31:0]             bank_lim_asize_o,
    input  logic [63:0]             bank_rdata_i
);

    typedef enum logic [1:0] {IDLE, RESP, AMO_RESP} state_e;

    localparam logic [3:0] AmoNone = 4'h0;
    localparam logic [3:0] AmoLr   = 4'hB;

    state_e     state_q, state_d;
    logic       lane_q;
    logic       err_q;
    logic [3:0] amo;
    logic       amo_ok;
    logic       illegal;
    logic       grant;
    logic       unused_addr;

    assign unused_addr = ^{data_addr_i[31:AddrMemWidth+3], data_addr_i[1:0]};

    // Decode AMO funct5 into the bank AMO code; flag undefined encodings.
    always_comb begin
        amo    = AmoNone;
        amo_ok = 1'b1;
        if (data_atop_i[5]) begin
            unique case (data_atop_i[4:0])
                5'b00001: amo = 4'h1;
                5'b00000: amo = 4'h2;
                5'b01100: amo = 4'h3;
                5'b01000: amo = 4'h4;
                5'b00100: amo = 4'h5;
                5'b10100: amo = 4'h6;
                5'b11100: amo = 4'h7;
                5'b10000: amo = 4'h8;
                5'b11000: amo = 4'h9;
                5'b00010: amo = 4'hB;
                5'b00011: amo = 4'hC;
                default: begin
                    amo    = AmoNone;
                    amo_ok = 1'b0;
                end
            endcase
        end
    end

    // Atomics must be full-word and use a defined funct5.
    assign illegal = data_atop_i[5] && (!amo_ok || (data_be_i != 4'b1111));

    assign bank_amo_o       = amo;
    assign bank_add_o       = data_addr_i[AddrMemWidth+2:3];
    assign bank_be_o        = data_addr_i[2] ? {data_be_i, 4'b0} : {4'b0, data_be_i};
    assign bank_wdata_o     = {data_wdata_i, data_wdata_i};
    assign bank_wen_o       = data_we_i;
    assign bank_lim_o       = data_lim_i;
    assign bank_lim_op_o    = data_lim_op_i;
    assign bank_lim_asize_o = data_lim_asize_i;

    assign grant = data_req_i && data_gnt_o;

    // Handshake and next state; AMO_RESP blocks the core for write-back.
    always_comb begin
        state_d    = IDLE;
        bank_req_o = 1'b0;
        data_gnt_o = 1'b0;
        if (state_q != AMO_RESP) begin
            bank_req_o = data_req_i && !illegal;
            data_gnt_o = illegal ? data_req_i : bank_gnt_i;
        end
        if (grant) begin
            if (!illegal && (amo != AmoNone) && (amo != AmoLr)) begin
                state_d = AMO_RESP;
            end else begin
                state_d = RESP;
            end
        end
    end

    // State, response lane and error flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lane_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                lane_q <= data_addr_i[2];
                err_q  <= illegal;
            end
        end
    end

    assign data_rvalid_o = (state_q != IDLE);
    assign data_err_o    = err_q && (state_q == RESP);
    assign data_rdata_o  = err_q  ? 32'h0 :
                           lane_q ? bank_rdata_i[63:32] : bank_rdata_i[31:0];

endmodule

// File: tb/tb_core_bank_adapter.sv
// tb_core_bank_adapter: directed tests for core_bank_adapter.
// Inputs change on negedge; outputs are sampled 1ns later.
module tb_core_bank_adapter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_err_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [5:0]  data_atop_i;
    logic        data_lim_i;
    logic [2:0]  data_lim_op_i;
    logic [31:0] data_lim_asize_i;
    logic [31:0] data_rdata_o;
    logic        bank_req_o;
    logic        bank_gnt_i;
    logic [15:0] bank_add_o;
    logic [3:0]  bank_amo_o;
    logic        bank_wen_o;
    logic [63:0] bank_wdata_o;
    logic [7:0]  bank_be_o;
    logic        bank_lim_o;
    logic [2:0]  bank_lim_op_o;
    logic [31:0] bank_lim_asize_o;
    logic [63:0] bank_rdata_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    core_bank_adapter #(.AddrMemWidth(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o),
        .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_atop_i(data_atop_i), .data_lim_i(data_lim_i),
        .data_lim_op_i(data_lim_op_i), .data_lim_asize_i(data_lim_asize_i),
        .data_rdata_o(data_rdata_o), .bank_req_o(bank_req_o),
        .bank_gnt_i(bank_gnt_i), .bank_add_o(bank_add_o),
        .bank_amo_o(bank_amo_o), .bank_wen_o(bank_wen_o),
        .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o),
        .bank_lim_o(bank_lim_o), .bank_lim_op_o(bank_lim_op_o),
        .bank_lim_asize_o(bank_lim_asize_o), .bank_rdata_i(bank_rdata_i)
    );

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        data_req_i = 0; data_addr_i = 0; data_we_i = 0; data_be_i = 4'hF;
        data_wdata_i = 0; data_atop_i = 0; data_lim_i = 1; data_lim_op_i = 3'd5;
        data_lim_asize_i = 32'h0000_0100; bank_gnt_i = 1; bank_rdata_i = 0;
        #12;
        checks++;
        if (data_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid got %0b exp 0", data_rvalid_o);
        end
        checks++;
        if (data_err_o !== 1'b0) begin
            errors++; $display("FAIL reset_err got %0b exp 0", data_err_o);
        end
        checks++;
        if (bank_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_bank_req got %0b exp 0", bank_req_o);
        end
        checks++;
        if ({bank_lim_o, bank_lim_op_o, bank_lim_asize_o} !== {1'b1, 3'd5, 32'h100}) begin
            errors++; $display("FAIL lim_passthru got %0b %0d %h", bank_lim_o, bank_lim_op_o, bank_lim_asize_o);
        end
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_load();
        data_req_i = 1; data_addr_i = 32'h0000_000C; data_we_i = 0;
        data_be_i = 4'hF; data_atop_i = 0; bank_gnt_i = 1;
        bank_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
        settle();
        checks++;
        if ({bank_req_o, data_gnt_o, bank_add_o, bank_be_o, bank_amo_o} !==
            {1'b1, 1'b1, 16'd1, 8'hF0, 4'h0}) begin
            errors++;
            $display("FAIL load_req got req=%0b gnt=%0b add=%h be=%h amo=%h exp 1 1 0001 f0 0",
                     bank_req_o, data_gnt_o, bank_add_o, bank_be_o, bank_amo_o);
        end
        step();
        data_req_i = 0;
        settle();
        checks++;
        if ({data_rvalid_o, data_err_o, data_rdata_o} !== {1'b1, 1'b0, 32'hAAAA_BBBB}) begin
            errors++;
            $display("FAIL load_resp got rv=%0b err=%0b rdata=%h exp 1 0 aaaabbbb",
                     data_rvalid_o, data_err_o, data_rdata_o);
        end
        step();
        checks++;
        if (data_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL load_idle got rv=%0b exp 0", data_rvalid_o);
        end
    endtask

    task automatic test_store();
        data_req_i = 1; data_addr_i = 32'h0000_0010; data_we_i = 1;
        data_be_i = 4'b0011; data_wdata_i = 32'h1234_5678; data_atop_i = 0;
        settle();
        checks++;
        if ({bank_be_o, bank_wdata_o, bank_wen_o, bank_add_o} !==
            {8'h03, 64'h1234_5678_1234_5678, 1'b1, 16'd2}) begin
            errors++;
            $display("FAIL store_req got be=%h wdata=%h wen=%0b add=%h exp 03 1234567812345678 1 0002",
                     bank_be_o, bank_wdata_o, bank_wen_o, bank_add_o);
        end
        step();
        data_req_i = 0; data_we_i = 0;
        settle();
        checks++;
        if ({data_rvalid_o, data_err_o} !== 2'b10) begin
            errors++; $display("FAIL store_resp got rv=%0b err=%0b exp 1 0", data_rvalid_o, data_err_o);
        end
        step();
    endtask

    task automatic test_amo_add();
        data_req_i = 1; data_addr_i = 32'h0000_0004; data_be_i = 4'hF;
        data_atop_i = 6'b100000; data_we_i = 0; bank_gnt_i = 1;
        bank_rdata_i = 64'h0000_0011_0000_0022;
        settle();
        checks++;
        if ({bank_amo_o, data_gnt_o, bank_req_o} !== {4'h2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL amo_grant got amo=%h gnt=%0b req=%0b exp 2 1 1", bank_amo_o, data_gnt_o, bank_req_o);
        end
        step();
        settle();
        checks++;
        if ({data_gnt_o, bank_req_o, data_rvalid_o, data_err_o, data_rdata_o} !==
            {1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0011}) begin
            errors++;
            $display("FAIL amo_block got gnt=%0b req=%0b rv=%0b err=%0b rdata=%h exp 0 0 1 0 00000011",
                     data_gnt_o, bank_req_o, data_rvalid_o, data_err_o, data_rdata_o);
        end
        step();
        settle();
        checks++;
        if ({data_gnt_o, bank_req_o, data_rvalid_o} !== 3'b110) begin
            errors++;
            $display("FAIL amo_second_grant got gnt=%0b req=%0b rv=%0b exp 1 1 0", data_gnt_o, bank_req_o, data_rvalid_o);
        end
        step();
        data_req_i = 0;
        settle();
        checks++;
        if ({data_rvalid_o, data_gnt_o} !== 2'b10) begin
            errors++; $display("FAIL amo_second_resp got rv=%0b gnt=%0b exp 1 0", data_rvalid_o, data_gnt_o);
        end
        step();
        data_atop_i = 0;
    endtask

    task automatic test_back_to_back();
        data_req_i = 1; data_addr_i = 32'h0000_0000; data_be_i = 4'hF;
        data_atop_i = 6'b100010; bank_gnt_i = 1;
        bank_rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
        settle();
        checks++;
        if ({bank_amo_o, data_gnt_o} !== {4'hB, 1'b1}) begin
            errors++; $display("FAIL lr_grant got amo=%h gnt=%0b exp b 1", bank_amo_o, data_gnt_o);
        end
        step();
        data_addr_i = 32'h0000_000C; data_atop_i = 0;
        settle();
        checks++;
        if ({data_rvalid_o, data_rdata_o, data_gnt_o} !== {1'b1, 32'h0BAD_F00D, 1'b1}) begin
            errors++;
            $display("FAIL lr_resp_load_grant got rv=%0b rdata=%h gnt=%0b exp 1 0badf00d 1",
                     data_rvalid_o, data_rdata_o, data_gnt_o);
        end
        step();
        data_req_i = 0;
        settle();
        checks++;
        if ({data_rvalid_o, data_rdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL b2b_load_resp got rv=%0b rdata=%h exp 1 deadbeef", data_rvalid_o, data_rdata_o);
        end
        step();
    endtask

    task automatic test_illegal();
        logic [5:0] atops [2];
        logic [3:0] bes [2];
        atops[0] = 6'b100111; bes[0] = 4'b1111;
        atops[1] = 6'b100000; bes[1] = 4'b0011;
        bank_gnt_i = 0; bank_rdata_i = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 2; i++) begin
            data_req_i = 1; data_addr_i = 32'h0000_0008;
            data_atop_i = atops[i]; data_be_i = bes[i];
            settle();
            checks++;
            if ({bank_req_o, data_gnt_o} !== 2'b01) begin
                errors++; $display("FAIL illegal_grant_%0d got req=%0b gnt=%0b exp 0 1", i, bank_req_o, data_gnt_o);
            end
            step();
            data_req_i = 0; data_atop_i = 0; data_be_i = 4'hF;
            settle();
            checks++;
            if ({data_rvalid_o, data_err_o, data_rdata_o} !== {1'b1, 1'b1, 32'h0}) begin
                errors++;
                $display("FAIL illegal_resp_%0d got rv=%0b err=%0b rdata=%h exp 1 1 00000000",
                         i, data_rvalid_o, data_err_o, data_rdata_o);
            end
            step();
            checks++;
            if ({data_rvalid_o, data_err_o} !== 2'b00) begin
                errors++; $display("FAIL illegal_idle_%0d got rv=%0b err=%0b exp 0 0", i, data_rvalid_o, data_err_o);
            end
        end
    endtask

    task automatic test_stall_reset();
        data_req_i = 1; data_addr_i = 32'h0000_0004; data_be_i = 4'hF;
        data_atop_i = 0; bank_gnt_i = 0; bank_rdata_i = 64'h5555_5555_0000_0000;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if ({bank_req_o, data_gnt_o, data_rvalid_o} !== 3'b100) begin
                errors++;
                $display("FAIL stall_%0d got req=%0b gnt=%0b rv=%0b exp 1 0 0", i, bank_req_o, data_gnt_o, data_rvalid_o);
            end
            step();
        end
        bank_gnt_i = 1;
        settle();
        checks++;
        if (data_gnt_o !== 1'b1) begin
            errors++; $display("FAIL stall_release_gnt got %0b exp 1", data_gnt_o);
        end
        @(posedge clk_i);
        #1;
        data_req_i = 0;
        rst_ni = 0;
        #1;
        checks++;
        if ({data_rvalid_o, data_err_o, data_rdata_o} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset got rv=%0b err=%0b rdata=%h exp 0 0 00000000",
                     data_rvalid_o, data_err_o, data_rdata_o);
        end
        step();
        rst_ni = 1;
        step();
        checks++;
        if (data_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL post_reset_rvalid got %0b exp 0", data_rvalid_o);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_amo_add();
        test_back_to_back();
        test_illegal();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
